dac_feed_scheduler: RTL and testbench

Sample-rate controller for the 2nd-order sigma-delta DAC.
- Shares the DAC input between two streaming sample sources: pulls one sample from each at a fixed sample rate, mixes them with saturation and applies a soft-start/soft-stop gain ramp (anti-pop).
- Drives the DAC's `d` input and holds the DAC in reset while idle.

---
 rtl/dac_feed_scheduler.sv | 140 ++++++++++++++
 tb/tb_dac_feed_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_feed_scheduler.sv
// Fixed-rate two-source puller/mixer with soft-start/stop gain ramp into the DAC; dac_d lands two edges after the tick edge.
// Sources see ready only on tick (no stalls; a missing sample is an underrun). DAC_FEED_UNDERRUN_HOLD_EN repeats the last sample on underrun.
module dac_feed_scheduler #(
  parameter int DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [15:0] s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [15:0] dac_d,
  output logic        dac_run,
  output logic        tick,
  output logic        underrun,
  input  logic        clr_underrun
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t        state_q, state_d;
  logic [8:0]    gain_q, gain_d;
  logic [CW-1:0] div_q, div_d;
  logic [15:0]   cap0_q, cap0_d, cap1_q, cap1_d;
  logic [15:0]   mix_q, mix_d, out_q, out_d;
  logic          cap_vld_q, cap_vld_d, mix_vld_q, mix_vld_d;
  logic          underrun_q, underrun_d;

  logic               div_wrap, tick_w;
  logic [16:0]        sum;
  logic [15:0]        sat;
  logic signed [24:0] prod;
  logic [8:0]         prod_unused;

  assign div_wrap = (div_q == CW'(DIV - 1));
  assign tick_w   = (state_q != IDLE) && div_wrap;

  assign sum  = {cap0_q[15], cap0_q} + {cap1_q[15], cap1_q};
  assign sat  = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7fff) : sum[15:0];
  // Gain is 0..256 so the shifted product always fits back into 16 bits.
  assign prod        = $signed({{9{mix_q[15]}}, mix_q}) * $signed({16'd0, gain_q});
  assign prod_unused = {prod[24], prod[7:0]};

  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    div_d      = div_q;
    cap0_d     = cap0_q;
    cap1_d     = cap1_q;
    cap_vld_d  = tick_w;
    mix_vld_d  = cap_vld_q;
    mix_d      = cap_vld_q ? sat : mix_q;
    out_d      = mix_vld_q ? prod[23:8] : out_q;
    underrun_d = underrun_q;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (tick_w && gain_q != 9'd256) gain_d = gain_q + 9'd1;
        if (!enable)                    state_d = RAMP_DOWN;
        else if (gain_d == 9'd256)      state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (tick_w && gain_q != 9'd0) gain_d = gain_q - 9'd1;
        if (enable)                   state_d = RAMP_UP;
        else if (gain_d == 9'd0)      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) div_d = div_wrap ? '0 : div_q + CW'(1);

    if (tick_w) begin
`ifdef DAC_FEED_UNDERRUN_HOLD_EN
      cap0_d = s0_valid ? s0_data : cap0_q;
      cap1_d = s1_valid ? s1_data : cap1_q;
`else
      cap0_d = s0_valid ? s0_data : 16'd0;
      cap1_d = s1_valid ? s1_data : 16'd0;
`endif
    end

    if (clr_underrun)                        underrun_d = 1'b0;
    if (tick_w && !(s0_valid && s1_valid))   underrun_d = 1'b1;

    // Entering IDLE silences the DAC and drops anything still in flight.
    if (state_q != IDLE && state_d == IDLE) begin
      div_d     = '0;
      cap0_d    = '0;
      cap1_d    = '0;
      cap_vld_d = 1'b0;
      mix_vld_d = 1'b0;
      mix_d     = '0;
      out_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gain_q     <= '0;
      div_q      <= '0;
      cap0_q     <= '0;
      cap1_q     <= '0;
      cap_vld_q  <= 1'b0;
      mix_vld_q  <= 1'b0;
      mix_q      <= '0;
      out_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      div_q      <= div_d;
      cap0_q     <= cap0_d;
      cap1_q     <= cap1_d;
      cap_vld_q  <= cap_vld_d;
      mix_vld_q  <= mix_vld_d;
      mix_q      <= mix_d;
      out_q      <= out_d;
      underrun_q <= underrun_d;
    end
  end

  assign s0_ready = tick_w;
  assign s1_ready = tick_w;
  assign tick     = tick_w;
  assign dac_d    = out_q;
  assign dac_run  = (state_q != IDLE);
  assign underrun = underrun_q;
endmodule

// File: tb/tb_dac_feed_scheduler.sv
// Bench for dac_feed_scheduler: directed test-plan scenarios plus random traffic against an integer reference model.
module tb_dac_feed_scheduler;
  localparam int DIV = 4;
`ifdef DAC_FEED_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, s0_valid, s1_valid, clr_underrun;
  logic [15:0] s0_data, s1_data;
  logic        s0_ready, s1_ready, dac_run, tick, underrun;
  logic [15:0] dac_d;

  dac_feed_scheduler #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .dac_d(dac_d), .dac_run(dac_run), .tick(tick),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=ramp up 2=run 3=ramp down; outputs queued by due edge.
  typedef struct { int due; int val; } pend_t;
  pend_t pq[$];
  int m_mode, m_gain, m_cnt, m_c0, m_c1, m_unr, m_dac, edge_no;

  function automatic bit m_tick();
    return (m_mode != 0) && (m_cnt == DIV - 1);
  endfunction

  function automatic int floor_div256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_step();
    bit tk;
    int nmode, ng;
    edge_no++;
    if (reset) begin
      m_mode = 0; m_gain = 0; m_cnt = 0; m_c0 = 0; m_c1 = 0; m_unr = 0; m_dac = 0;
      pq.delete();
      return;
    end
    tk = m_tick();
    while (pq.size() > 0 && pq[0].due == edge_no) m_dac = pq.pop_front().val;
    nmode = m_mode;
    ng    = m_gain;
    case (m_mode)
      0: if (enable) nmode = 1;
      1: begin
        if (tk && ng < 256) ng++;
        if (!enable) nmode = 3; else if (ng == 256) nmode = 2;
      end
      2: if (!enable) nmode = 3;
      default: begin
        if (tk && ng > 0) ng--;
        if (enable) nmode = 1; else if (ng == 0) nmode = 0;
      end
    endcase
    if (tk) begin
      if (s0_valid) m_c0 = int'($signed(s0_data)); else if (!HOLD) m_c0 = 0;
      if (s1_valid) m_c1 = int'($signed(s1_data)); else if (!HOLD) m_c1 = 0;
      pq.push_back('{edge_no + 2, floor_div256(clamp16(m_c0 + m_c1) * ng)});
    end
    if (tk && !(s0_valid && s1_valid)) m_unr = 1;
    else if (clr_underrun)             m_unr = 0;
    m_cnt = (m_mode == 0 || tk) ? 0 : m_cnt + 1;
    if (m_mode != 0 && nmode == 0) begin
      m_dac = 0; m_c0 = 0; m_c1 = 0; m_cnt = 0;
      pq.delete();
    end
    m_mode = nmode;
    m_gain = ng;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("dac_d",    int'($signed(dac_d)), m_dac);
    chk("dac_run",  int'(dac_run),  int'(m_mode != 0));
    chk("tick",     int'(tick),     int'(m_tick()));
    chk("s0_ready", int'(s0_ready), int'(m_tick()));
    chk("s1_ready", int'(s1_ready), int'(m_tick()));
    chk("underrun", int'(underrun), m_unr);
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * DIV && !m_tick(); i++) cycle();
    chk("wait_tick", int'(m_tick()), 1);
  endtask

  int seen[$];
  int last, rdy_cnt;

  task automatic run_record(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (int'($signed(dac_d)) != last) begin
        last = int'($signed(dac_d));
        seen.push_back(last);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clr_underrun = 1'b0;
    s0_data = '0; s1_data = '0; s0_valid = 1'b1; s1_valid = 1'b1;
    m_mode = 0; m_gain = 0; m_cnt = 0; m_c0 = 0; m_c1 = 0; m_unr = 0; m_dac = 0; edge_no = 0;
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_dac_d", int'(dac_d), 0);
    chk("rst_run", int'(dac_run), 0);
    chk("rst_ready", int'(s0_ready), 0);

    // Soft start with a constant 1000 on source 0.
    s0_data = 16'd1000; s1_data = 16'd0; enable = 1'b1;
    cycle();
    chk("run_latency", int'(dac_run), 1);
    last = 0;
    run_record(256 * DIV + 16);
    chk("ramp_step1", seen.size() > 0 ? seen[0] : -1, 3);
    chk("ramp_step2", seen.size() > 1 ? seen[1] : -1, 7);
    chk("ramp_step3", seen.size() > 2 ? seen[2] : -1, 11);
    chk("ramp_full", int'($signed(dac_d)), 1000);

    s0_data = 16'd30000; s1_data = 16'd10000;
    for (int i = 0; i < 2 * DIV; i++) cycle();
    chk("sat_pos", int'($signed(dac_d)), 32767);
    s0_data = 16'(-30000); s1_data = 16'(-10000);
    for (int i = 0; i < 2 * DIV; i++) cycle();
    chk("sat_neg", int'($signed(dac_d)), -32768);

    // One missing source-1 sample in RUN.
    s0_data = 16'd500; s1_data = 16'd200;
    for (int i = 0; i < 2 * DIV; i++) cycle();
    chk("pre_underrun", int'(underrun), 0);
    wait_tick();
    s1_valid = 1'b0;
    cycle();
    s1_valid = 1'b1;
    cycle(); cycle();
    chk("underrun_dac", int'($signed(dac_d)), HOLD ? 700 : 500);
    chk("underrun_set", int'(underrun), 1);
    if (m_tick()) cycle();
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    chk("underrun_clr", int'(underrun), 0);
    wait_tick();
    s1_valid = 1'b0; clr_underrun = 1'b1;
    cycle();
    s1_valid = 1'b1; clr_underrun = 1'b0;
    chk("set_beats_clr", int'(underrun), 1);

    // Reset mid-RUN, then the ramp restarts from gain 0.
    s0_data = 16'd1000; s1_data = 16'd0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_dac_d", int'(dac_d), 0);
    chk("midrst_run", int'(dac_run), 0);
    chk("midrst_underrun", int'(underrun), 0);
    chk("midrst_ready", int'(s0_ready), 0);
    for (int i = 0; i < DIV + 3; i++) cycle();
    chk("restart_first", int'($signed(dac_d)), 3);

    // Ramp down from gain 100.
    for (int i = 0; i < 200 * DIV && m_gain != 100; i++) cycle();
    chk("reach_gain100", m_gain, 100);
    enable = 1'b0;
    seen.delete();
    last = int'($signed(dac_d));
    for (int i = 0; i < 200 * DIV && m_mode != 0; i++) run_record(1);
    chk("down_step1", seen.size() > 0 ? seen[0] : -1, 390);
    chk("down_step2", seen.size() > 1 ? seen[1] : -1, 386);
    chk("down_run", int'(dac_run), 0);
    chk("down_dac_d", int'(dac_d), 0);
    rdy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      rdy_cnt += int'(s0_ready);
    end
    chk("idle_no_ready", rdy_cnt, 0);

    // Random traffic.
    enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      s0_data  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h7fff : 16'h8000) : 16'($urandom);
      s1_data  = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h7fff : 16'h8000) : 16'($urandom);
      s0_valid = ($urandom_range(0, 9) != 0);
      s1_valid = ($urandom_range(0, 9) != 0);
      clr_underrun = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 400) == 0) enable = ~enable;
      reset = ($urandom_range(0, 2000) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
